// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone B4 pipelined slave between NUM_MASTERS masters.
// A grant is held for the whole bus cycle; routing is combinational from the registered grant.
module wb_arbiter #(
  parameter int NUM_MASTERS = 2
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
  input  logic [16*NUM_MASTERS-1:0] m_adr_i,
  input  logic [32*NUM_MASTERS-1:0] m_dat_i,
  output logic [NUM_MASTERS-1:0]    m_stall_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [31:0]               m_dat_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic [3:0]                wb_sel_o,
  output logic [15:0]               wb_adr_o,
  output logic [31:0]               wb_dat_o,
  input  logic [31:0]               wb_dat_i,
  input  logic                      wb_stall_i,
  input  logic                      wb_ack_i,
  output logic [NUM_MASTERS-1:0]    grant_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IW-1:0] LAST_INIT = IW'(NUM_MASTERS - 1);
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_GRANTED = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;

  logic          found_s;
  logic [IW-1:0] pick_s;
  logic [IW-1:0] cand_s;
  int            sum_s;

  logic [3:0]  sel_a [NUM_MASTERS];
  logic [15:0] adr_a [NUM_MASTERS];
  logic [31:0] dat_a [NUM_MASTERS];

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_slice
    assign sel_a[gi] = m_sel_i[gi*4 +: 4];
    assign adr_a[gi] = m_adr_i[gi*16 +: 16];
    assign dat_a[gi] = m_dat_i[gi*32 +: 32];
  end

  // Scan last+1, last+2, ... ; on handover the current holder (offset N) is excluded.
  always_comb begin
    found_s = 1'b0;
    pick_s  = last_q;
    cand_s  = last_q;
    sum_s   = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      sum_s = int'(last_q) + k;
      if (sum_s >= NUM_MASTERS) begin
        sum_s = sum_s - NUM_MASTERS;
      end else begin
        sum_s = sum_s;
      end
      cand_s = IW'(sum_s);
      if (!found_s && m_cyc_i[cand_s] && ((state_q == ST_IDLE) || (k < NUM_MASTERS))) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d = ST_GRANTED;
          grant_d = pick_s;
          last_d  = pick_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANTED: begin
        if (m_cyc_i[grant_q]) begin
          state_d = ST_GRANTED;
        end else if (found_s) begin
          grant_d = pick_s;
          last_d  = pick_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      grant_q <= {IW{1'b0}};
      last_q  <= LAST_INIT;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Idle drives a quiet slave bus and stalls every master; acks are dropped.
  always_comb begin
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_sel_o  = 4'h0;
    wb_adr_o  = 16'h0000;
    wb_dat_o  = 32'h0000_0000;
    m_stall_o = {NUM_MASTERS{1'b1}};
    m_ack_o   = {NUM_MASTERS{1'b0}};
    grant_o   = {NUM_MASTERS{1'b0}};
    if (state_q == ST_GRANTED) begin
      wb_cyc_o           = m_cyc_i[grant_q];
      wb_stb_o           = m_stb_i[grant_q];
      wb_we_o            = m_we_i[grant_q];
      wb_sel_o           = sel_a[grant_q];
      wb_adr_o           = adr_a[grant_q];
      wb_dat_o           = dat_a[grant_q];
      m_stall_o[grant_q] = wb_stall_i;
      m_ack_o[grant_q]   = wb_ack_i;
      grant_o[grant_q]   = 1'b1;
    end else begin
      grant_o = {NUM_MASTERS{1'b0}};
    end
  end

  assign m_dat_o = wb_dat_i;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter: behavioural masters and slave, a round-robin reference model,
// and a monitor scoreboarding slave-side transfers and acknowledges.
module tb_wb_arbiter;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] cyc = '0, stb = '0, we = '0;
  logic [3:0]  sel [N];
  logic [15:0] adr [N];
  logic [31:0] dat [N];
  logic [4*N-1:0]  sel_f;
  logic [16*N-1:0] adr_f;
  logic [32*N-1:0] dat_f;
  logic        wb_stall = 1'b0, wb_ack = 1'b0;
  logic [31:0] rdata = 32'h0;

  logic [N-1:0] m_stall_o, m_ack_o, grant_o;
  logic [31:0]  m_dat_o, wb_dat_o;
  logic         wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]   wb_sel_o;
  logic [15:0]  wb_adr_o;

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign sel_f[gi*4 +: 4]   = sel[gi];
    assign adr_f[gi*16 +: 16] = adr[gi];
    assign dat_f[gi*32 +: 32] = dat[gi];
  end

  wb_arbiter #(.NUM_MASTERS(N)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_sel_i(sel_f), .m_adr_i(adr_f), .m_dat_i(dat_f),
    .m_stall_o(m_stall_o), .m_ack_o(m_ack_o), .m_dat_o(m_dat_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(rdata),
    .wb_stall_i(wb_stall), .wb_ack_i(wb_ack), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit busy;
  int g, last, pend;
  bit active [N];
  bit hold [N];
  int beats [N];
  int acks [N];

  // stimulus knobs
  int req_pct = 100, maxb = 1, stall_pct = 0;
  logic [N-1:0] req_mask = '1;

  logic [63:0] exp_xfer [$];
  logic [63:0] exp_ack [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int from, input int span, input logic [N-1:0] req);
    for (int k = 1; k <= span; k++) begin
      if (req[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  // Applies the round-robin rules to the inputs that were present at the edge just taken.
  task automatic model_edge();
    int p;
    if (!rst_n) begin
      busy = 1'b0; g = 0; last = N - 1; pend = 0;
      for (int i = 0; i < N; i++) begin
        active[i] = 1'b0; hold[i] = 1'b0; beats[i] = 0; acks[i] = 0;
      end
    end else begin
      bit acc;
      acc = busy && cyc[g] && stb[g] && !wb_stall;
      if (busy && wb_ack) begin acks[g]--; pend--; end
      if (acc) begin beats[g]--; pend++; end
      for (int i = 0; i < N; i++) hold[i] = stb[i] && !(acc && i == g);
      if (!busy) begin
        p = rr_pick(last, N, cyc);
        if (p >= 0) begin busy = 1'b1; g = p; last = p; end
      end else if (!cyc[g]) begin
        p = rr_pick(g, N - 1, cyc);
        if (p >= 0) begin g = p; last = p; end
        else busy = 1'b0;
      end
    end
  endtask

  task automatic new_beat(input int i);
    stb[i] = 1'b1; we[i] = 1'($urandom % 2); sel[i] = 4'($urandom);
    adr[i] = 16'($urandom); dat[i] = $urandom;
  endtask

  task automatic drive_masters();
    for (int i = 0; i < N; i++) begin
      if (!active[i]) begin
        if (req_mask[i] && ($urandom % 100) < req_pct) begin
          active[i] = 1'b1; beats[i] = $urandom_range(1, maxb); acks[i] = beats[i];
          cyc[i] = 1'b1; new_beat(i);
        end else begin
          cyc[i] = 1'b0; stb[i] = 1'b0;
        end
      end else if (beats[i] == 0 && acks[i] == 0) begin
        active[i] = 1'b0; cyc[i] = 1'b0; stb[i] = 1'b0;
      end else if (hold[i]) begin
        stb[i] = 1'b1;
      end else if (beats[i] > 0 && ($urandom % 100) < 80) begin
        new_beat(i);
      end else begin
        stb[i] = 1'b0;
      end
    end
  endtask

  task automatic drive_slave();
    logic [N-1:0] one;
    one = '0;
    one[g] = 1'b1;
    wb_stall = (($urandom % 100) < stall_pct);
    rdata = $urandom;
    if (busy && pend > 0 && ($urandom % 100) < 70) begin
      wb_ack = 1'b1; exp_ack.push_back({32'(one), rdata});
    end else if (!busy && pend == 0 && ($urandom % 100) < 10) begin
      wb_ack = 1'b1; exp_ack.push_back({32'h0, rdata});
    end else begin
      wb_ack = 1'b0;
    end
    if (busy && cyc[g] && stb[g] && !wb_stall)
      exp_xfer.push_back({11'h0, we[g], sel[g], adr[g], dat[g]});
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg, es;
    eg = '0; es = '1;
    if (busy) begin eg[g] = 1'b1; es[g] = wb_stall; end
    check("grant", 64'(grant_o), 64'(eg));
    check("stall", 64'(m_stall_o), 64'(es));
    check("cyc_stb", {62'h0, wb_cyc_o, wb_stb_o}, busy ? {62'h0, cyc[g], stb[g]} : 64'h0);
    if (!busy) check("idle_fields", {11'h0, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}, 64'h0);
    check("rdata", 64'(m_dat_o), 64'(rdata));
  endtask

  task automatic cycle_step(input bit rst_next);
    @(posedge clk);
    model_edge();
    #1;
    rst_n = rst_next;
    drive_masters();
    drive_slave();
    #1;
    check_outputs();
  endtask

  // Monitor: pops the scoreboard whenever the DUT accepts a beat or presents an acknowledge.
  always @(negedge clk) begin
    logic [63:0] e;
    if (wb_cyc_o === 1'b1 && wb_stb_o === 1'b1 && wb_stall === 1'b0) begin
      if (exp_xfer.size() == 0) begin
        checks++; errors++;
        $display("FAIL xfer_unexpected: got adr %0h expected none at %0t", wb_adr_o, $time);
      end else begin
        check("xfer", {11'h0, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}, exp_xfer.pop_front());
      end
    end
    if (exp_xfer.size() != 0) begin
      checks++; errors++;
      $display("FAIL xfer_missing: got no transfer expected %0h at %0t", exp_xfer[0], $time);
      exp_xfer.delete();
    end
    if ((|m_ack_o) === 1'b1 || wb_ack === 1'b1) begin
      if (exp_ack.size() == 0) begin
        checks++; errors++;
        $display("FAIL ack_unexpected: got %0b expected none at %0t", m_ack_o, $time);
      end else begin
        e = exp_ack.pop_front();
        check("ack_mask", 64'(m_ack_o), {32'h0, e[63:32]});
        if (e[63:32] != 32'h0) check("ack_data", 64'(m_dat_o), {32'h0, e[31:0]});
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin sel[i] = '0; adr[i] = '0; dat[i] = '0; end
    // reset held with both masters requesting, then release
    req_pct = 100; maxb = 1; stall_pct = 0; req_mask = '1;
    cycle_step(1'b0);
    cycle_step(1'b0);
    cycle_step(1'b1);
    // back-to-back single beats from both masters: strict alternation
    for (int c = 0; c < 40; c++) cycle_step(1'b1);
    // only master 1 requests, then a reset lands while it holds the bus
    req_mask = 2'b10; maxb = 4; stall_pct = 50;
    for (int c = 0; c < 4; c++) cycle_step(1'b1);
    req_mask = '1; req_pct = 100;
    cycle_step(1'b0);
    for (int c = 0; c < 10; c++) cycle_step(1'b1);
    // mixed random traffic with occasional resets
    req_pct = 40; maxb = 3; stall_pct = 30;
    for (int c = 0; c < 1500; c++) cycle_step(($urandom % 100) >= 2);
    // heavy slave back-pressure
    stall_pct = 80; req_pct = 60;
    for (int c = 0; c < 300; c++) cycle_step(1'b1);
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Round-robin arbiter that shares one Wishbone B4 pipelined slave bus between `NUM_MASTERS` masters, e.g. `wbm_spi` plus on-chip masters. It sits between the masters and the peripheral interconnect. It holds a grant for a master's whole bus cycle (`cyc` high) and routes `stb`/`stall`/`ack`/data accordingly. Bus widths match the codebase: 16-bit address, 32-bit data, 4-bit select.

## Interface
- `NUM_MASTERS`, 2: number of requesting masters (2..8). Per-master vectors are flattened, with master *i* at slice *i*.
- `wb_clk_i`  in  1  bus clock; all state changes on the rising edge.
- `wb_rst_ni`  in  1  synchronous, active-low reset.
- `m_cyc_i`  in  NUM_MASTERS  per-master cycle request.
- `m_stb_i`  in  NUM_MASTERS  per-master strobe.
- `m_we_i`  in  NUM_MASTERS  per-master write enable.
- `m_sel_i`  in  4*NUM_MASTERS  per-master byte select.
- `m_adr_i`  in  16*NUM_MASTERS  per-master address.
- `m_dat_i`  in  32*NUM_MASTERS  per-master write data.
- `m_stall_o`  out  NUM_MASTERS  per-master stall.
- `m_ack_o`  out  NUM_MASTERS  per-master acknowledge.
- `m_dat_o`  out  32  read data, broadcast to all masters (valid only with own ack).
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1 each  slave-side control.
- `wb_sel_o`  out  4  slave-side byte select.
- `wb_adr_o`  out  16  slave-side address.
- `wb_dat_o`  out  32  slave-side write data.
- `wb_dat_i`  in  32  slave read data.
- `wb_stall_i`, `wb_ack_i`  in  1 each  slave stall / acknowledge.
- `grant_o`  out  NUM_MASTERS  one-hot current grant; all zero when idle.

## Operation
- Registered state:
  - `busy` (IDLE/GRANTED).
  - `grant` index.
  - `last`: index of the most recently granted master.
- Reset (`wb_rst_ni`=0 at an edge):
  - `busy`=0, `grant`=0, `last`=NUM_MASTERS-1, so master 0 has first priority.
- IDLE:
  - If any `m_cyc_i` bit is set, select the first requester scanning `last+1, last+2, …` modulo NUM_MASTERS.
  - Next state: GRANTED, with `grant`=selected and `last`=selected.
- GRANTED, granted master's `m_cyc_i` still high: hold the grant.
- GRANTED, granted master's `m_cyc_i` low at an edge (end of cycle):
  - Re-arbitrate at that same edge among the other requesters, in the same scan order starting after `grant`.
  - If one is found, grant it directly, with no idle cycle in between.
  - Otherwise go to IDLE.
- Arbitration never preempts a master whose `cyc` is high.
- Routing is combinational from the registered grant.
- When GRANTED:
  - `wb_cyc_o` = `m_cyc_i[grant]`, `wb_stb_o` = `m_stb_i[grant]`.
  - `wb_we_o`, `wb_sel_o`, `wb_adr_o` and `wb_dat_o` are the granted master's slices.
  - `m_stall_o[grant]` = `wb_stall_i`; `m_ack_o[grant]` = `wb_ack_i`.
  - All other masters: stall=1, ack=0.
  - `m_dat_o` = `wb_dat_i` always.
- When IDLE:
  - All slave-side outputs are 0.
  - `m_stall_o` is all ones and `m_ack_o` is all zeros.
- `wb_ack_i` arriving while IDLE is dropped and is not forwarded to any master.

## Timing
- Values during and immediately after reset:
  - `wb_cyc_o`/`wb_stb_o`/`wb_we_o`=0; `wb_sel_o`/`wb_adr_o`/`wb_dat_o`=0.
  - `m_stall_o`=all ones, `m_ack_o`=0, `grant_o`=0.
- Grant latency from idle: `m_cyc_i` first sampled high at edge N gives `wb_cyc_o` high in cycle N+1. Across that edge the master sees stall=1, so it holds `stb` and its request fields.
- Handover latency: the granted master drops `cyc` before edge N; the next requester appears on the slave bus in cycle N+1. `wb_cyc_o` is low for the cycle in which the previous master's `cyc` is low.
- Pipelined transfers pass through with zero added latency: `stb`, `stall` and `ack` are combinational paths.
- Simultaneous cases:
  - Requests arriving on the same edge are resolved purely by the round-robin order.
  - A master that drops and re-raises `cyc` is ordered last behind the other requesters.
- Reset mid-cycle: bus outputs are forced idle at the next edge, and any outstanding transfer is abandoned. Masters are reset by the same signal.

## Test plan
- Reset: hold `wb_rst_ni`=0 for 3 cycles with `m_cyc_i`=2'b11 -> `wb_cyc_o`=0, `m_stall_o`=2'b11, `m_ack_o`=0, `grant_o`=0. Release -> `grant_o`=2'b01 one cycle later.
- Single read: master 1 cyc/stb, `adr`=0x0010, `we`=0 -> one cycle later `wb_adr_o`=0x0010, `m_stall_o[1]`=0. Slave acks with 0xDEADBEEF -> `m_ack_o`=2'b10, `m_dat_o`=0xDEADBEEF.
- Contention: both masters request on the same edge after reset -> master 0 is served first and `m_stall_o[1]`=1 throughout. Master 0 drops cyc -> `grant_o`=2'b10 on the next edge, with no idle cycle.
- Fairness: both masters issue back-to-back single-beat cycles continuously -> `grant_o` sequence is 01,10,01,10. Neither master is served twice in a row.
- Slave stall: granted master 0 write of 0x12345678 with `wb_stall_i`=1 for 4 cycles -> `m_stall_o[0]`=1 for those cycles with `wb_stb_o` held. Then exactly one `wb_ack_i` -> `m_ack_o`=2'b01.
- Mid-cycle reset: assert reset while master 1 is granted with `wb_cyc_o`=1 -> next cycle `wb_cyc_o`=0 and `grant_o`=0. After release, master 0 is prioritized.
